// File: rtl/drive_speed_tracker.sv
// drive_speed_tracker: integrates drive commands into saturating left/right
// wheel speeds, converts each speed to two decimal digits with a sequential
// divide-by-10 engine and drives four seven-segment displays (HEX4..HEX7).

// Seven-segment decoder, active-low segments {g,f,e,d,c,b,a}; codes 10-15 blank.
module seven_seg (
    input  logic [3:0] code,
    output logic [6:0] seg
);
    // Map one digit code to its segment pattern
    always_comb begin
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

module drive_speed_tracker #(
    parameter int SPEED_W       = 7,
    parameter int MAX_SPEED     = 99,
    parameter int GAIN          = 2,
    parameter int TURN_CUT      = 1,
    parameter int DECAY_UPDATES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               update,
    input  logic [1:0]         instruction,
    input  logic [2:0]         torque,
    output logic [SPEED_W-1:0] speed_l,
    output logic [SPEED_W-1:0] speed_r,
    output logic               busy,
    output logic               disp_valid,
    output logic               overrun,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX6,
    output logic [6:0]         HEX7
);
    localparam int SW    = SPEED_W + 2;
    localparam int CNT_W = (DECAY_UPDATES < 2) ? 1 : $clog2(DECAY_UPDATES + 1);
    localparam logic signed [SW-1:0]      MAX_S = SW'(MAX_SPEED);
    localparam logic [SPEED_W-1:0]        MAX_U = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0]        TEN   = SPEED_W'(10);
    localparam logic [2:0]                TCUT  = 3'(TURN_CUT);
    localparam logic [CNT_W:0]            DCY   = (CNT_W+1)'(DECAY_UPDATES);
    localparam logic [3:0]                BLANK = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CONVERT, S_SHOW} state_t;

    state_t             r_state;
    logic [1:0]         r_instr;
    logic [2:0]         r_torque;
    logic [SPEED_W-1:0] r_speed_l, r_speed_r;
    logic [CNT_W-1:0]   r_cnt_l, r_cnt_r;
    logic [SPEED_W-1:0] r_rem_l, r_rem_r;
    logic [3:0]         r_tens_l, r_tens_r;
    logic [3:0]         r_dig_lt, r_dig_lo, r_dig_rt, r_dig_ro;
    logic               r_busy, r_disp_valid, r_overrun;

    logic [2:0]            w_t;
    logic [SW-1:0]         w_e_mag, w_c_mag, w_mag_l, w_mag_r;
    logic                  w_neg, w_hit_l, w_hit_r;
    logic signed [SW-1:0]  w_delta_l, w_delta_r;
    logic [CNT_W-1:0]      w_cnt_l_nxt, w_cnt_r_nxt;
    logic [SPEED_W-1:0]    w_new_l, w_new_r;
    logic [3:0]            w_code4, w_code5, w_code6, w_code7;

    // Signed add with clamp to [0, MAX_SPEED]; the wide intermediate never wraps
    function automatic logic [SPEED_W-1:0] clamp_add(input logic [SPEED_W-1:0] spd,
                                                     input logic signed [SW-1:0] delta);
        logic signed [SW-1:0] sum;
        sum = $signed({2'b00, spd}) + delta;
        if (sum[SW-1])
            return '0;
        else if (sum > MAX_S)
            return MAX_U;
        else
            return sum[SPEED_W-1:0];
    endfunction

    // True when this zero-delta update is the one that triggers a coast step
    function automatic logic decay_hit(input logic [CNT_W-1:0] cnt);
        return (DECAY_UPDATES != 0) && (({1'b0, cnt} + 1'b1) == DCY);
    endfunction

    // Per-channel deltas, coast counters and clamped next speeds
    always_comb begin
        w_t     = (r_torque <= 3'd4) ? r_torque : 3'd0;
        w_e_mag = SW'(w_t) * SW'(GAIN);
        w_c_mag = (w_t > TCUT) ? SW'(w_t - TCUT) * SW'(GAIN) : '0;
        w_mag_l = (r_instr == 2'b10) ? w_c_mag : w_e_mag;
        w_mag_r = (r_instr == 2'b11) ? w_c_mag : w_e_mag;
        w_neg   = (r_instr == 2'b01);

        w_hit_l = (w_mag_l == '0) && decay_hit(r_cnt_l);
        w_hit_r = (w_mag_r == '0) && decay_hit(r_cnt_r);

        if (w_mag_l != '0)
            w_delta_l = w_neg ? -$signed(w_mag_l) : $signed(w_mag_l);
        else
            w_delta_l = w_hit_l ? '1 : '0;
        if (w_mag_r != '0)
            w_delta_r = w_neg ? -$signed(w_mag_r) : $signed(w_mag_r);
        else
            w_delta_r = w_hit_r ? '1 : '0;

        w_cnt_l_nxt = (w_mag_l != '0 || w_hit_l || DECAY_UPDATES == 0) ? '0 : r_cnt_l + 1'b1;
        w_cnt_r_nxt = (w_mag_r != '0 || w_hit_r || DECAY_UPDATES == 0) ? '0 : r_cnt_r + 1'b1;

        w_new_l = clamp_add(r_speed_l, w_delta_l);
        w_new_r = clamp_add(r_speed_r, w_delta_r);
    end

    // Control FSM with registered status outputs and the divide-by-10 engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_instr      <= '0;
            r_torque     <= '0;
            r_speed_l    <= '0;
            r_speed_r    <= '0;
            r_cnt_l      <= '0;
            r_cnt_r      <= '0;
            r_rem_l      <= '0;
            r_rem_r      <= '0;
            r_tens_l     <= '0;
            r_tens_r     <= '0;
            r_dig_lt     <= BLANK;
            r_dig_lo     <= BLANK;
            r_dig_rt     <= BLANK;
            r_dig_ro     <= BLANK;
            r_busy       <= 1'b0;
            r_disp_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            if (update && r_state != S_IDLE)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (update) begin
                        r_instr  <= instruction;
                        r_torque <= torque;
                        r_busy   <= 1'b1;
                        r_state  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_speed_l <= w_new_l;
                    r_speed_r <= w_new_r;
                    r_cnt_l   <= w_cnt_l_nxt;
                    r_cnt_r   <= w_cnt_r_nxt;
                    r_rem_l   <= w_new_l;
                    r_rem_r   <= w_new_r;
                    r_tens_l  <= '0;
                    r_tens_r  <= '0;
                    r_state   <= S_CONVERT;
                end
                S_CONVERT: begin
                    if (r_rem_l < TEN && r_rem_r < TEN) begin
                        r_state <= S_SHOW;
                    end else begin
                        if (r_rem_l >= TEN) begin
                            r_rem_l  <= r_rem_l - TEN;
                            r_tens_l <= r_tens_l + 4'd1;
                        end
                        if (r_rem_r >= TEN) begin
                            r_rem_r  <= r_rem_r - TEN;
                            r_tens_r <= r_tens_r + 4'd1;
                        end
                    end
                end
                S_SHOW: begin
                    r_dig_lt     <= r_tens_l;
                    r_dig_lo     <= r_rem_l[3:0];
                    r_dig_rt     <= r_tens_r;
                    r_dig_ro     <= r_rem_r[3:0];
                    r_disp_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Display blanking is combinational so enable acts within the cycle
    always_comb begin
        w_code4 = enable ? r_dig_rt : BLANK;
        w_code5 = enable ? r_dig_ro : BLANK;
        w_code6 = enable ? r_dig_lt : BLANK;
        w_code7 = enable ? r_dig_lo : BLANK;
    end

    seven_seg u_hex4 (.code(w_code4), .seg(HEX4));
    seven_seg u_hex5 (.code(w_code5), .seg(HEX5));
    seven_seg u_hex6 (.code(w_code6), .seg(HEX6));
    seven_seg u_hex7 (.code(w_code7), .seg(HEX7));

    assign speed_l    = r_speed_l;
    assign speed_r    = r_speed_r;
    assign busy       = r_busy;
    assign disp_valid = r_disp_valid;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_drive_speed_tracker.sv
// Directed testbench for drive_speed_tracker with default parameters.
module tb_drive_speed_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       update = 1'b0;
    logic [1:0] instruction = 2'b00;
    logic [2:0] torque = 3'd0;
    logic [6:0] speed_l, speed_r;
    logic       busy, disp_valid, overrun;
    logic [6:0] HEX4, HEX5, HEX6, HEX7;

    int vectors = 0;
    int miscompares = 0;

    drive_speed_tracker #(
        .SPEED_W(7), .MAX_SPEED(99), .GAIN(2), .TURN_CUT(1), .DECAY_UPDATES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .update(update),
        .instruction(instruction), .torque(torque),
        .speed_l(speed_l), .speed_r(speed_r), .busy(busy),
        .disp_valid(disp_valid), .overrun(overrun),
        .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_exp(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {HEX4,HEX5,HEX6,HEX7} for left speed l and right speed r
    function automatic logic [27:0] hex_exp(input int l, input int r);
        return {seg_exp(r / 10), seg_exp(r % 10), seg_exp(l / 10), seg_exp(l % 10)};
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_update(input logic [1:0] ins, input logic [2:0] tq);
        @(posedge clk); #1;
        instruction = ins; torque = tq; update = 1'b1;
        @(posedge clk); #1 update = 1'b0;
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (speed_l !== 7'd0 || speed_r !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_speed got %0d/%0d expected 0/0", speed_l, speed_r);
        end
        vectors++;
        if ({busy, disp_valid, overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b expected 000", {busy, disp_valid, overrun});
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== 28'hFFFFFFF) begin
            miscompares++;
            $display("FAIL reset_hex got %h expected fffffff", {HEX4, HEX5, HEX6, HEX7});
        end
    endtask

    task automatic test_latency_pulse();
        repeat (6) do_update(2'b00, 3'd4);
        repeat (3) do_update(2'b00, 3'd0);
        vectors++;
        if (speed_l !== 7'd48 || speed_r !== 7'd48) begin
            miscompares++;
            $display("FAIL lat_pre got %0d/%0d expected 48/48", speed_l, speed_r);
        end
        // fourth zero-delta update coasts both wheels to 47
        @(posedge clk); #1;
        instruction = 2'b00; torque = 3'd0; update = 1'b1;
        @(posedge clk); #1 update = 1'b0;            // edge k
        vectors++;
        if (speed_l !== 7'd48 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lat_k got speed %0d busy %b expected 48 1", speed_l, busy);
        end
        @(posedge clk); #1;                           // edge k+1
        vectors++;
        if (speed_l !== 7'd47 || speed_r !== 7'd47) begin
            miscompares++;
            $display("FAIL lat_k1 got %0d/%0d expected 47/47", speed_l, speed_r);
        end
        for (int i = 2; i <= 6; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (disp_valid !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL lat_early edge k+%0d got dv %b busy %b expected 0 1", i, disp_valid, busy);
            end
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(48, 48)) begin
            miscompares++;
            $display("FAIL lat_hold_hex got %h expected %h", {HEX4, HEX5, HEX6, HEX7}, hex_exp(48, 48));
        end
        @(posedge clk); #1;                           // edge k+7
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(47, 47) || disp_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_k7 got hex %h dv %b busy %b expected %h 1 0",
                     {HEX4, HEX5, HEX6, HEX7}, disp_valid, busy, hex_exp(47, 47));
        end
        @(posedge clk); #1;
        vectors++;
        if (disp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_pulse_end got dv %b expected 0", disp_valid);
        end
    endtask

    task automatic test_reset_mid_conversion();
        @(posedge clk); #1;
        instruction = 2'b00; torque = 3'd0; update = 1'b1;
        @(posedge clk); #1 update = 1'b0;            // edge k
        repeat (2) @(posedge clk);                    // k+2: converting 47
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (speed_l !== 7'd0 || speed_r !== 7'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state got %0d/%0d busy %b expected 0/0 0", speed_l, speed_r, busy);
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== 28'hFFFFFFF) begin
            miscompares++;
            $display("FAIL midrst_hex got %h expected fffffff", {HEX4, HEX5, HEX6, HEX7});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_update(2'b00, 3'd0);
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(0, 0) || speed_l !== 7'd0) begin
            miscompares++;
            $display("FAIL midrst_after got hex %h speed %0d expected %h 0",
                     {HEX4, HEX5, HEX6, HEX7}, speed_l, hex_exp(0, 0));
        end
    endtask

    task automatic test_forward_saturation();
        for (int i = 1; i <= 14; i++) begin
            int e;
            e = (8 * i > 99) ? 99 : 8 * i;
            do_update(2'b00, 3'd4);
            vectors++;
            if (speed_l !== 7'(e) || speed_r !== 7'(e)) begin
                miscompares++;
                $display("FAIL fwd_step%0d got %0d/%0d expected %0d/%0d", i, speed_l, speed_r, e, e);
            end
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(99, 99)) begin
            miscompares++;
            $display("FAIL fwd_hex got %h expected %h", {HEX4, HEX5, HEX6, HEX7}, hex_exp(99, 99));
        end
    endtask

    task automatic test_reverse_turns();
        logic [1:0] ins_v [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [2:0] tq_v  [6] = '{3'd4, 3'd1, 3'd3, 3'd3, 3'd1, 3'd4};
        int         el_v  [6] = '{8, 10, 4, 0, 0, 8};
        int         er_v  [6] = '{8, 10, 4, 0, 2, 8};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_update(ins_v[i], tq_v[i]);
            vectors++;
            if (speed_l !== 7'(el_v[i]) || speed_r !== 7'(er_v[i])) begin
                miscompares++;
                $display("FAIL revturn_%0d got %0d/%0d expected %0d/%0d",
                         i, speed_l, speed_r, el_v[i], er_v[i]);
            end
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(8, 8)) begin
            miscompares++;
            $display("FAIL revturn_hex got %h expected %h", {HEX4, HEX5, HEX6, HEX7}, hex_exp(8, 8));
        end
    endtask

    task automatic test_decay_invalid();
        logic [2:0] tq_v [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd6, 3'd7, 3'd5};
        int         ex_v [12] = '{6, 6, 6, 5, 5, 5, 5, 4, 4, 4, 4, 3};
        apply_reset();
        do_update(2'b00, 3'd3);
        for (int i = 0; i < 12; i++) begin
            do_update(2'b00, tq_v[i]);
            vectors++;
            if (speed_l !== 7'(ex_v[i]) || speed_r !== 7'(ex_v[i])) begin
                miscompares++;
                $display("FAIL decay_%0d got %0d/%0d expected %0d/%0d",
                         i, speed_l, speed_r, ex_v[i], ex_v[i]);
            end
        end
    endtask

    task automatic test_overrun_enable();
        apply_reset();
        repeat (7) do_update(2'b00, 3'd4);
        do_update(2'b00, 3'd2);
        vectors++;
        if (speed_l !== 7'd60 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_pre got %0d overrun %b expected 60 0", speed_l, overrun);
        end
        // held for 10 edges; the 62 conversion keeps the engine busy for all of them
        @(posedge clk); #1;
        instruction = 2'b00; torque = 3'd1; update = 1'b1;
        repeat (10) @(posedge clk);
        #1 update = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        vectors++;
        if (speed_l !== 7'd62 || speed_r !== 7'd62 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_held got %0d/%0d overrun %b expected 62/62 1", speed_l, speed_r, overrun);
        end
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(62, 62)) begin
            miscompares++;
            $display("FAIL ovr_hex got %h expected %h", {HEX4, HEX5, HEX6, HEX7}, hex_exp(62, 62));
        end
        enable = 1'b0;
        #1;
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== 28'hFFFFFFF || speed_l !== 7'd62) begin
            miscompares++;
            $display("FAIL en_off got hex %h speed %0d expected fffffff 62", {HEX4, HEX5, HEX6, HEX7}, speed_l);
        end
        enable = 1'b1;
        #1;
        vectors++;
        if ({HEX4, HEX5, HEX6, HEX7} !== hex_exp(62, 62)) begin
            miscompares++;
            $display("FAIL en_on got %h expected %h", {HEX4, HEX5, HEX6, HEX7}, hex_exp(62, 62));
        end
        apply_reset();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear got %b expected 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_latency_pulse();
        test_reset_mid_conversion();
        test_forward_saturation();
        test_reverse_turns();
        test_decay_invalid();
        test_overrun_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
